// File: rtl/cic_decim_param_if.sv
`default_nettype none
// ============================================================================
//  Module   : cic_decim_param_if
//  Brief    : Sample-stream bundle for the CIC decimator: input sample with
//             valid, decimated output sample with valid pulse.
//  Revision : 1.0 - initial release
// ============================================================================
interface cic_decim_param_if #(
  parameter int WIN  = 16,
  parameter int WOUT = 16
);
  logic signed [WIN-1:0]  i_data;
  logic                   val_in;
  logic signed [WOUT-1:0] o_data;
  logic                   val_out;

  // Sample source side
  modport master (output i_data, val_in, input o_data, val_out);
  // Filter side
  modport slave  (input i_data, val_in, output o_data, val_out);
endinterface
`default_nettype wire

// File: rtl/cic_decim_param.sv
`default_nettype none
// ============================================================================
//  Module   : cic_decim_param
//  Brief    : Parametrised CIC decimator. Registered input, N pipelined
//             integrators, decimate by R, N combs with differential delay M,
//             round-half-up and positive saturation on the output register.
//  Revision : 1.0 - initial release
// ============================================================================
module cic_decim_param #(
  parameter int WIN  = 16,
  parameter int WOUT = 16,
  parameter int N    = 3,
  parameter int R    = 8,
  parameter int M    = 1
) (
  input  wire logic             clk,
  input  wire logic             rst,
  cic_decim_param_if.slave      bus
);

  localparam int C_WG   = N * $clog2(R * M);
  localparam int C_WACC = WIN + C_WG;
  localparam int C_WD   = C_WACC - WOUT;
  localparam int C_CW   = $clog2(R);
  localparam logic [C_CW-1:0]      C_CNT_MAX = C_CW'(R - 1);
  localparam logic signed [WOUT-1:0] C_OMAX  = {1'b0, {(WOUT-1){1'b1}}};

  logic signed [WIN-1:0]    r_x;
  logic                     r_v;
  logic signed [C_WACC-1:0] r_integ [N];
  logic [C_CW-1:0]          r_cnt;
  logic signed [C_WACC-1:0] r_s;
  logic                     r_dec_v;
  logic signed [C_WACC-1:0] r_comb  [N];
  logic signed [C_WACC-1:0] r_dly   [N][M];
  logic                     r_comb_v;
  logic signed [WOUT-1:0]   r_odata;
  logic                     r_vout;

  logic signed [C_WACC-1:0] w_x_ext;
  logic signed [C_WACC-1:0] w_cin   [N];
  logic signed [WOUT-1:0]   w_top;
  logic signed [WOUT:0]     w_t;
  logic signed [WOUT-1:0]   w_odata;
  logic                     w_unused;

  assign w_x_ext = {{C_WG{r_x[WIN-1]}}, r_x};

  // Input register stage
  always_ff @(posedge clk) begin
    if (rst) begin
      r_x <= '0;
      r_v <= 1'b0;
    end else begin
      r_x <= bus.i_data;
      r_v <= bus.val_in;
    end
  end

  // Integrator chain; each stage adds the pre-edge value of its predecessor
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < N; k++) r_integ[k] <= '0;
    end else if (r_v) begin
      r_integ[0] <= r_integ[0] + w_x_ext;
      for (int k = 1; k < N; k++) r_integ[k] <= r_integ[k] + r_integ[k-1];
    end
  end

  // Decimation counter; snapshot the last integrator once every R samples
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= '0;
      r_s     <= '0;
      r_dec_v <= 1'b0;
    end else begin
      r_dec_v <= 1'b0;
      if (r_v) begin
        if (r_cnt == C_CNT_MAX) begin
          r_cnt   <= '0;
          r_s     <= r_integ[N-1];
          r_dec_v <= 1'b1;
        end else begin
          r_cnt <= r_cnt + C_CW'(1);
        end
      end
    end
  end

  // Comb stage inputs: the snapshot feeds stage 0, each comb feeds the next
  always_comb begin
    w_cin[0] = r_s;
    for (int k = 1; k < N; k++) w_cin[k] = r_comb[k-1];
  end

  // Comb chain with M-deep delay lines advancing only on decimated samples
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < N; k++) begin
        r_comb[k] <= '0;
        for (int j = 0; j < M; j++) r_dly[k][j] <= '0;
      end
      r_comb_v <= 1'b0;
    end else begin
      r_comb_v <= r_dec_v;
      if (r_dec_v) begin
        for (int k = 0; k < N; k++) begin
          r_comb[k]   <= w_cin[k] - r_dly[k][M-1];
          r_dly[k][0] <= w_cin[k];
          for (int j = 1; j < M; j++) r_dly[k][j] <= r_dly[k][j-1];
        end
      end
    end
  end

  assign w_top = r_comb[N-1][C_WACC-1:C_WD];

  generate
    if (C_WD > 0) begin : g_round
      // Round half up: add the most significant discarded bit
      assign w_t = $signed({w_top[WOUT-1], w_top})
                 + $signed({{WOUT{1'b0}}, r_comb[N-1][C_WD-1]});
    end else begin : g_trunc
      assign w_t = {w_top[WOUT-1], w_top};
    end
  endgenerate

  // Rounding can only push past the positive limit; clamp there
  assign w_odata  = (w_t[WOUT] != w_t[WOUT-1]) ? C_OMAX : w_t[WOUT-1:0];
  assign w_unused = ^r_comb[N-1];

  // Output register; o_data holds between valid pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      r_odata <= '0;
      r_vout  <= 1'b0;
    end else begin
      r_vout <= r_comb_v;
      if (r_comb_v) r_odata <= w_odata;
    end
  end

  assign bus.o_data  = r_odata;
  assign bus.val_out = r_vout;

endmodule
`default_nettype wire

// File: tb/tb_cic_decim_param.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cic_decim_param
//  Brief    : Self-checking bench for cic_decim_param. Three configurations
//             (defaults; R=5; Wout=8) share one input stream and are compared
//             every cycle against an array-based CIC reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cic_decim_param;

  localparam int NSTG = 3;
  localparam int MD   = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;

  cic_decim_param_if #(.WIN(16), .WOUT(16)) ifa ();
  cic_decim_param_if #(.WIN(16), .WOUT(16)) ifb ();
  cic_decim_param_if #(.WIN(16), .WOUT(8))  ifc ();

  cic_decim_param #(.WIN(16), .WOUT(16), .N(3), .R(8), .M(1))
    dut_a (.clk(clk), .rst(rst), .bus(ifa));
  cic_decim_param #(.WIN(16), .WOUT(16), .N(3), .R(5), .M(1))
    dut_b (.clk(clk), .rst(rst), .bus(ifb));
  cic_decim_param #(.WIN(16), .WOUT(8),  .N(3), .R(8), .M(1))
    dut_c (.clk(clk), .rst(rst), .bus(ifc));

  always #5 clk = ~clk;

  int     n_tests = 0;
  int     n_fail  = 0;
  int     cfg_r    [3] = '{8, 5, 8};
  int     cfg_wout [3] = '{16, 16, 8};
  longint hist [$];
  bit     pend_v   [3][4];
  longint pend_d   [3][4];
  bit     out_v    [3];
  longint out_d    [3];
  longint exp_last [3];

  task automatic chk(input string tag, input logic signed [63:0] got,
                     input logic signed [63:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Output for pulse p: cascade of delayed running sums over the accepted
  // samples, every R-th sum, then N delayed differences, then round/saturate.
  function automatic longint model_out(input int r, input int wout, input int p);
    int     len = p * r;
    int     wd  = 16 + NSTG * $clog2(r * MD) - wout;
    longint a[], b[], s[], c[], d[];
    longint acc, v, t, mx;
    a = new[len];
    for (int i = 0; i < len; i++) a[i] = hist[i];
    for (int k = 0; k < NSTG; k++) begin
      b = new[len];
      acc = 0;
      for (int m = 0; m < len; m++) begin b[m] = acc; acc += a[m]; end
      a = b;
    end
    s = new[p + 1];
    s[0] = 0;
    for (int j = 1; j <= p; j++) s[j] = a[j * r - 1];
    c = new[p + 1];
    c[0] = 0;
    for (int j = 1; j <= p; j++) c[j] = s[j] - ((j - MD >= 1) ? s[j - MD] : 0);
    for (int k = 2; k <= NSTG; k++) begin
      d = new[p + 1];
      d[0] = 0;
      for (int j = 1; j <= p; j++)
        d[j] = ((j - 1 >= 1) ? c[j - 1] : 0) - ((j - 1 - MD >= 1) ? c[j - 1 - MD] : 0);
      c = d;
    end
    v  = c[p];
    t  = (wd > 0) ? ((v >>> wd) + ((v >>> (wd - 1)) & 1)) : v;
    mx = (longint'(1) <<< (wout - 1)) - 1;
    if (t > mx) t = mx;
    return t;
  endfunction

  // Advance the reference by one clock edge with the given pin values
  task automatic model_edge(input logic v, input logic signed [15:0] d, input logic r);
    for (int c = 0; c < 3; c++) begin
      out_v[c] = pend_v[c][1];
      out_d[c] = pend_d[c][1];
      pend_v[c][1] = pend_v[c][2]; pend_d[c][1] = pend_d[c][2];
      pend_v[c][2] = pend_v[c][3]; pend_d[c][2] = pend_d[c][3];
      pend_v[c][3] = 1'b0;         pend_d[c][3] = 0;
    end
    if (r) begin
      hist.delete();
      for (int c = 0; c < 3; c++) begin
        for (int j = 0; j < 4; j++) begin pend_v[c][j] = 1'b0; pend_d[c][j] = 0; end
        out_v[c] = 1'b0;
        exp_last[c] = 0;
      end
    end else if (v) begin
      hist.push_back(longint'(d));
      for (int c = 0; c < 3; c++) begin
        if (hist.size() % cfg_r[c] == 0) begin
          pend_v[c][3] = 1'b1;
          pend_d[c][3] = model_out(cfg_r[c], cfg_wout[c], hist.size() / cfg_r[c]);
        end
      end
    end
    for (int c = 0; c < 3; c++) if (out_v[c]) exp_last[c] = out_d[c];
  endtask

  task automatic check_all();
    logic signed [63:0] od [3];
    logic               vo [3];
    od[0] = ifa.o_data;  vo[0] = ifa.val_out;
    od[1] = ifb.o_data;  vo[1] = ifb.val_out;
    od[2] = ifc.o_data;  vo[2] = ifc.val_out;
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("val_out_cfg%0d", c), {63'd0, vo[c]}, {63'd0, out_v[c]});
      chk($sformatf("o_data_cfg%0d", c), od[c], exp_last[c]);
    end
  endtask

  task automatic step(input logic v, input logic signed [15:0] d, input logic r);
    ifa.i_data = d; ifb.i_data = d; ifc.i_data = d;
    ifa.val_in = v; ifb.val_in = v; ifc.val_in = v;
    rst = r;
    @(posedge clk);
    model_edge(v, d, r);
    #1;
    check_all();
  endtask

  initial begin
    int first_hit;
    int prev;
    logic rv;
    ifa.i_data = '0; ifb.i_data = '0; ifc.i_data = '0;
    ifa.val_in = 1'b0; ifb.val_in = 1'b0; ifc.val_in = 1'b0;

    // Reset state
    step(0, 16'sd0, 1); step(0, 16'sd0, 1);
    chk("reset_o_data_a", ifa.o_data, 0);
    chk("reset_val_out_a", {63'd0, ifa.val_out}, 0);
    chk("reset_o_data_c", ifc.o_data, 0);

    // DC 1000, continuous
    step(0, 16'sd0, 0);
    first_hit = -1;
    for (int i = 0; i < 128; i++) begin
      step(1, 16'sd1000, 0);
      if (first_hit < 0 && ifa.val_out === 1'b1) first_hit = i + 1;
    end
    chk("first_pulse_cycle", first_hit, 11);
    chk("dc1000_a", ifa.o_data, 1000);
    chk("dc1000_b", ifb.o_data, 244);
    chk("dc1000_c", ifc.o_data, 4);

    // Negative then positive full scale
    step(0, 16'sd0, 1);
    for (int i = 0; i < 128; i++) step(1, -16'sd32768, 0);
    chk("negfs_a", ifa.o_data, -32768);
    chk("negfs_b", ifb.o_data, -8000);
    chk("negfs_c", ifc.o_data, -128);
    for (int i = 0; i < 128; i++) step(1, 16'sd32767, 0);
    chk("posfs_a", ifa.o_data, 32767);
    chk("posfs_b", ifb.o_data, 8000);
    chk("posfs_sat_c", ifc.o_data, 127);

    // 1024 and -1000
    step(0, 16'sd0, 1);
    for (int i = 0; i < 128; i++) step(1, 16'sd1024, 0);
    chk("dc1024_b", ifb.o_data, 250);
    chk("dc1024_a", ifa.o_data, 1024);
    for (int i = 0; i < 128; i++) step(1, -16'sd1000, 0);
    chk("dcm1000_b", ifb.o_data, -244);
    chk("dcm1000_a", ifa.o_data, -1000);

    // Gapped valid, one sample every third cycle
    step(0, 16'sd0, 1);
    prev = -1;
    for (int i = 0; i < 384; i++) begin
      step((i % 3) == 0, 16'sd500, 0);
      if (ifa.val_out === 1'b1) begin
        if (prev >= 0) chk("gap_spacing", i - prev, 24);
        prev = i;
      end
    end
    chk("gap500_a", ifa.o_data, 500);
    chk("gap500_b", ifb.o_data, 122);
    chk("gap500_c", ifc.o_data, 2);

    // Reset after 5 of 8 samples
    for (int i = 0; i < 5; i++) step(1, 16'sd500, 0);
    step(0, 16'sd0, 1);
    chk("midrst_o_data", ifa.o_data, 0);
    chk("midrst_val_out", {63'd0, ifa.val_out}, 0);
    for (int i = 0; i < 8; i++) step(1, 16'sd500, 0);
    step(0, 16'sd0, 0);
    step(0, 16'sd0, 0);
    chk("midrst_no_early", {63'd0, ifa.val_out}, 0);
    step(0, 16'sd0, 0);
    chk("midrst_pulse", {63'd0, ifa.val_out}, 1);
    step(0, 16'sd0, 0);
    chk("midrst_pulse_width", {63'd0, ifa.val_out}, 0);

    // Half-LSB rounding on the 8-bit output
    step(0, 16'sd0, 1);
    for (int i = 0; i < 128; i++) step(1, 16'sd384, 0);
    chk("round_c", ifc.o_data, 2);
    chk("round_a", ifa.o_data, 384);

    // Randomised samples and valid pattern
    step(0, 16'sd0, 1);
    for (int i = 0; i < 600; i++) begin
      rv = ($urandom_range(0, 3) != 0);
      step(rv, 16'($urandom), 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
